// File: rtl/mem_map_pkg.sv
// Shared memory map for the block-RAM front ends: widths, I/O register
// addresses, region and FSM state types, and the address decode rule.
package mem_map_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int RAM_AW    = 10;
  localparam int RAM_DEPTH = 1 << RAM_AW;
  localparam int SW_W      = 10;

  localparam logic [ADDR_W-1:0] IO_SW_ADDR  = 16'hFFF0;
  localparam logic [ADDR_W-1:0] IO_LED_ADDR = 16'hFFF1;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_SW,
    REG_LED,
    REG_UNMAPPED
  } region_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP
  } state_e;

  // The full address is compared so that 0x0400 and up never alias onto RAM.
  function automatic region_e decode_region(input logic [ADDR_W-1:0] addr);
    region_e region;
    if ({16'b0, addr} < 32'(RAM_DEPTH)) begin
      region = REG_RAM;
    end else if (addr == IO_SW_ADDR) begin
      region = REG_SW;
    end else if (addr == IO_LED_ADDR) begin
      region = REG_LED;
    end else begin
      region = REG_UNMAPPED;
    end
    return region;
  endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational CPU-address to memory-region decoder, shared by the
// port-A controller and the port-B client.
module mem_addr_decode
  import mem_map_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output region_e           region
);

  assign region = decode_region(addr);

endmodule

// File: rtl/mem_ctrl.sv
// Port-A front end of the dual-port block RAM: single load/store handshake,
// address decode into RAM / switch / LED space, and RAM read-latency absorption.
module mem_ctrl
  import mem_map_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              ram_en,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [SW_W-1:0]   io_sw,
  output logic [DATA_W-1:0] io_led
);

  state_e            state_q, state_d;
  region_e           region_q, region_d;
  region_e           addr_region;
  logic              we_q, we_d;
  logic              ram_en_q, ram_en_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] io_led_q, io_led_d;

  mem_addr_decode u_decode (
    .addr   (addr),
    .region (addr_region)
  );

  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    we_d        = we_q;
    ram_en_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    io_led_d    = io_led_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          we_d        = we;
          region_d    = addr_region;
          ram_addr_d  = addr[RAM_AW-1:0];
          ram_wdata_d = wdata;
          ram_en_d    = we && (addr_region == REG_RAM);
          state_d     = ACCESS;
        end
      end

      // ram_wdata_q doubles as the latched store data for the LED register.
      ACCESS: begin
        if (we_q && (region_q == REG_LED)) begin
          io_led_d = ram_wdata_q;
        end
        state_d = CAPTURE;
      end

      CAPTURE: begin
        case (region_q)
          REG_RAM:  rdata_d = ram_rdata;
          REG_SW:   rdata_d = {{(DATA_W-SW_W){1'b0}}, io_sw};
          REG_LED:  rdata_d = io_led_q;
          default:  rdata_d = '0;
        endcase
        done_d  = 1'b1;
        err_d   = (region_q == REG_UNMAPPED);
        state_d = RESP;
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      region_q    <= REG_RAM;
      we_q        <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      io_led_q    <= '0;
    end else begin
      state_q     <= state_d;
      region_q    <= region_d;
      we_q        <= we_d;
      ram_en_q    <= ram_en_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      io_led_q    <= io_led_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign ram_en    = ram_en_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign io_led    = io_led_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a write-through registered RAM on port A, a
// transaction-level reference model checked every cycle, and directed tests.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ready;
  logic        done;
  logic [15:0] rdata;
  logic        err;
  logic        ram_en;
  logic [9:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [9:0]  io_sw;
  logic [15:0] io_led;

  int checks = 0;
  int fails  = 0;
  int en_count = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .io_sw     (io_sw),
    .io_led    (io_led)
  );

  // Port-A of the block RAM: registered, one-cycle latency, write-through.
  logic [15:0] ram_mem [0:1023];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_mem[ram_addr] <= ram_wdata;
      ram_rdata         <= ram_wdata;
    end else begin
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  // Reference model: tracks each accepted transaction as a set of
  // scheduled events (cycle of done, ram_en, LED update) from its accept cycle.
  int          m_cyc = 0;
  int          m_next_free = 0;
  int          m_done_at = -1;
  int          m_en_at = -1;
  int          m_led_at = -1;
  bit          m_live = 1'b0;
  logic [15:0] m_rdata, m_pend_rdata, m_led, m_pend_led, m_en_wdata;
  logic [9:0]  m_en_addr;
  logic        m_pend_err;
  logic [15:0] m_mem [0:1023];

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_live      = 1'b1;
        m_next_free = m_cyc + 1;
        m_done_at   = -1;
        m_en_at     = -1;
        m_led_at    = -1;
        m_rdata     = 16'h0000;
        m_led       = 16'h0000;
      end else if (m_live && req && m_cyc >= m_next_free) begin
        m_done_at   = m_cyc + 3;
        m_next_free = m_cyc + 4;
        m_pend_err  = 1'b0;
        m_en_at     = -1;
        if (addr < 16'd1024) begin
          if (we) begin
            m_mem[addr[9:0]] = wdata;
            m_pend_rdata     = wdata;
            m_en_at          = m_cyc + 1;
            m_en_addr        = addr[9:0];
            m_en_wdata       = wdata;
          end else begin
            m_pend_rdata = m_mem[addr[9:0]];
          end
        end else if (addr == 16'hFFF0) begin
          m_pend_rdata = {6'b0, io_sw};
        end else if (addr == 16'hFFF1) begin
          if (we) begin
            m_pend_led   = wdata;
            m_led_at     = m_cyc + 2;
            m_pend_rdata = wdata;
          end else begin
            m_pend_rdata = m_led;
          end
        end else begin
          m_pend_rdata = 16'h0000;
          m_pend_err   = 1'b1;
        end
      end
      m_cyc++;
      if (m_cyc == m_done_at) m_rdata = m_pend_rdata;
      if (m_cyc == m_led_at)  m_led   = m_pend_led;
    end
  end

  // Per-cycle comparison against the model, mid-cycle away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (ram_en === 1'b1) en_count++;
      if (m_live) begin
        checkOutput("ready",  ready,  m_cyc >= m_next_free);
        checkOutput("done",   done,   m_cyc == m_done_at);
        checkOutput("err",    err,    (m_cyc == m_done_at) && m_pend_err);
        checkOutput("rdata",  rdata,  m_rdata);
        checkOutput("io_led", io_led, m_led);
        checkOutput("ram_en", ram_en, m_cyc == m_en_at);
        if (m_cyc == m_en_at) begin
          checkOutput("ram_addr",  ram_addr,  m_en_addr);
          checkOutput("ram_wdata", ram_wdata, m_en_wdata);
        end
      end
    end
  end

  // Presents one request until accepted; returns mid-cycle of T+1 with req low.
  task automatic applyStimulus(input logic s_we, input logic [15:0] s_addr,
                               input logic [15:0] s_wdata);
    int guard = 0;
    @(negedge clk);
    req = 1'b1; we = s_we; addr = s_addr; wdata = s_wdata;
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) begin
      checks++;
      fails++;
      $display("[TB] FAIL accept_timeout: got ready=%b, want 1", ready);
    end
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic waitDone(input int start, output logic [15:0] rd,
                          output logic e, output int lat);
    lat = start;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("[TB] FAIL done_timeout: got done=%b after %0d cycles, want 1", done, lat);
    end
    rd = rdata;
    e  = err;
  endtask

  logic [15:0] rd;
  logic        e;
  int          lat;
  int          e0;
  int          acc, nd, prev_d;
  logic        acc_now;
  logic [15:0] hs_addr [0:2];

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; io_sw = '0;
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = 16'h5A00 ^ 16'(i);
      m_mem[i]   = 16'h5A00 ^ 16'(i);
    end
    repeat (3) @(negedge clk);
    checkOutput("rst_ready",     ready,     1);
    checkOutput("rst_done",      done,      0);
    checkOutput("rst_err",       err,       0);
    checkOutput("rst_rdata",     rdata,     0);
    checkOutput("rst_ram_en",    ram_en,    0);
    checkOutput("rst_ram_addr",  ram_addr,  0);
    checkOutput("rst_ram_wdata", ram_wdata, 0);
    checkOutput("rst_io_led",    io_led,    0);
    reset = 1'b0;

    // Store then load of RAM word 5
    e0 = en_count;
    applyStimulus(1'b1, 16'h0005, 16'hBEEF);
    waitDone(1, rd, e, lat);
    checkOutput("st5_rdata", rd, 16'hBEEF);
    checkOutput("st5_err", e, 0);
    checkOutput("st5_latency", lat, 3);
    checkOutput("st5_en_cycles", en_count - e0, 1);
    applyStimulus(1'b0, 16'h0005, 16'h0000);
    waitDone(1, rd, e, lat);
    checkOutput("ld5_rdata", rd, 16'hBEEF);
    checkOutput("ld5_latency", lat, 3);
    checkOutput("ld5_en_cycles", en_count - e0, 1);

    // RAM top boundary and the first unmapped word
    applyStimulus(1'b1, 16'h03FF, 16'h1111);
    waitDone(1, rd, e, lat);
    checkOutput("st3ff_err", e, 0);
    e0 = en_count;
    applyStimulus(1'b1, 16'h0400, 16'h2222);
    waitDone(1, rd, e, lat);
    checkOutput("st400_err", e, 1);
    checkOutput("st400_rdata", rd, 16'h0000);
    checkOutput("st400_en_cycles", en_count - e0, 0);
    applyStimulus(1'b0, 16'h03FF, 16'h0000);
    waitDone(1, rd, e, lat);
    checkOutput("ld3ff_rdata", rd, 16'h1111);
    applyStimulus(1'b0, 16'h0000, 16'h0000);
    waitDone(1, rd, e, lat);
    checkOutput("ld0_rdata", rd, 16'h5A00);
    checkOutput("ld0_err", e, 0);

    // Memory-mapped I/O
    io_sw = 10'h2A5;
    applyStimulus(1'b0, 16'hFFF0, 16'h0000);
    waitDone(1, rd, e, lat);
    checkOutput("ldsw_rdata", rd, 16'h02A5);
    applyStimulus(1'b1, 16'hFFF1, 16'h00F0);
    checkOutput("led_before", io_led, 16'h0000);
    @(negedge clk);
    checkOutput("led_after_access", io_led, 16'h00F0);
    waitDone(2, rd, e, lat);
    checkOutput("stled_rdata", rd, 16'h00F0);
    applyStimulus(1'b0, 16'hFFF1, 16'h0000);
    waitDone(1, rd, e, lat);
    checkOutput("ldled_rdata", rd, 16'h00F0);
    e0 = en_count;
    applyStimulus(1'b1, 16'hFFF0, 16'h1234);
    waitDone(1, rd, e, lat);
    checkOutput("stsw_err", e, 0);
    checkOutput("stsw_en_cycles", en_count - e0, 0);
    checkOutput("stsw_led", io_led, 16'h00F0);
    applyStimulus(1'b0, 16'h8000, 16'h0000);
    waitDone(1, rd, e, lat);
    checkOutput("unmapped_err", e, 1);
    checkOutput("unmapped_rdata", rd, 16'h0000);

    // req held high across three back-to-back loads
    hs_addr[0] = 16'h0005; hs_addr[1] = 16'h03FF; hs_addr[2] = 16'h0000;
    acc = 0; nd = 0; prev_d = -1;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = hs_addr[0];
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        nd++;
        if (prev_d >= 0) checkOutput("hs_spacing", k - prev_d, 4);
        prev_d = k;
      end
      acc_now = ready && req;
      @(negedge clk);
      if (acc_now) begin
        acc++;
        if (acc < 3) addr = hs_addr[acc];
        else req = 1'b0;
      end
    end
    checkOutput("hs_done_count", nd, 3);
    checkOutput("hs_accept_count", acc, 3);

    // Reset during ACCESS of an LED store
    applyStimulus(1'b1, 16'hFFF1, 16'h00AA);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_acc_ready", ready, 1);
    checkOutput("rst_acc_led", io_led, 16'h0000);

    // Reset during CAPTURE of a load
    applyStimulus(1'b0, 16'h03FF, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_cap_ready", ready, 1);
    checkOutput("rst_cap_led", io_led, 16'h0000);
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) nd++;
      @(negedge clk);
    end
    checkOutput("rst_no_done", nd, 0);

    applyStimulus(1'b0, 16'h0005, 16'h0000);
    waitDone(1, rd, e, lat);
    checkOutput("post_rst_rdata", rd, 16'hBEEF);
    checkOutput("post_rst_latency", lat, 3);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
